// File: rtl/pwm_color_mixer_pkg.sv
// Shared mode encoding and helpers for the PWM colour mixer.
package pwm_color_mixer_pkg;

    typedef enum logic [1:0] {
        MODE_STEP   = 2'b00,
        MODE_BRIGHT = 2'b01,
        MODE_FADE   = 2'b10
    } mode_t;

    localparam int RESET_INDEX = 0;

    // MODE button walks STEP -> BRIGHT -> FADE -> STEP.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_STEP:   return MODE_BRIGHT;
            MODE_BRIGHT: return MODE_FADE;
            default:     return MODE_STEP;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability filter and a 1-cycle press pulse
// on an accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             level_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 2'b00;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync_reg  <= {sync_reg[0], raw_i};
            press_reg <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stability run.
            if (sync_reg[1] == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= sync_reg[1];
                press_reg <= sync_reg[1];
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level_o = level_reg;
    assign press_o = press_reg;

endmodule

// File: rtl/pwm_color_mixer.sv
// PWM colour mixer: mode FSM, colour index / brightness level, free-running PWM,
// triangle fade engine and registered active-low LED drive.
module pwm_color_mixer #(
    parameter int CHANNELS        = 3,
    parameter int PWM_BITS        = 8,
    parameter int LEVEL_BITS      = 2,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int FADE_TICKS      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_next,
    input  logic                btn_mode,
    output logic [CHANNELS-1:0] led_n,
    output logic [1:0]          mode_o
);
    import pwm_color_mixer_pkg::*;

    localparam int DUTY_W = PWM_BITS + 1;
    localparam int TICK_W = (FADE_TICKS > 1) ? $clog2(FADE_TICKS) : 1;
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(FADE_TICKS - 1);
    localparam logic [PWM_BITS-1:0] FADE_MAX  = '1;

    logic next_press, mode_press;
    logic next_level_unused, mode_level_unused;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_btn (
        .clk(clk), .rst_n(rst_n), .raw_i(btn_next),
        .level_o(next_level_unused), .press_o(next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_btn (
        .clk(clk), .rst_n(rst_n), .raw_i(btn_mode),
        .level_o(mode_level_unused), .press_o(mode_press)
    );

    mode_t               mode_reg, mode_next;
    logic [CHANNELS-1:0] index_reg, index_next, index_inc, fade_index;
    logic [LEVEL_BITS-1:0] level_reg, level_next;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [PWM_BITS-1:0] fade_reg, fade_next;
    logic                fade_up_reg, fade_up_next;
    logic [TICK_W-1:0]   tick_reg, tick_next;
    logic [DUTY_W-1:0]   duty;
    logic                pwm_on;
    logic [CHANNELS-1:0] led_n_next, led_n_reg;

    assign index_inc  = index_reg + 1'b1;
    // A completed fade cycle never lands on the all-off colour.
    assign fade_index = (index_inc == '0) ? CHANNELS'(1) : index_inc;

    always_comb begin
        mode_next    = mode_reg;
        index_next   = index_reg;
        level_next   = level_reg;
        fade_next    = fade_reg;
        fade_up_next = fade_up_reg;
        tick_next    = tick_reg;
        if (mode_press) begin
            mode_next = next_mode(mode_reg);
            if (mode_next == MODE_FADE) begin
                fade_next    = '0;
                fade_up_next = 1'b1;
                tick_next    = '0;
            end
        end else if (next_press && mode_reg == MODE_STEP) begin
            index_next = index_inc;
        end else if (next_press && mode_reg == MODE_BRIGHT) begin
            level_next = level_reg + 1'b1;
        end else if (mode_reg == MODE_FADE && pwm_cnt_reg == FADE_MAX) begin
            if (tick_reg == TICK_LAST) begin
                tick_next = '0;
                if (fade_up_reg) begin
                    fade_next = fade_reg + 1'b1;
                    if (fade_reg == FADE_MAX - 1'b1)
                        fade_up_next = 1'b0;
                end else begin
                    fade_next = fade_reg - 1'b1;
                    if (fade_reg == PWM_BITS'(1)) begin
                        fade_up_next = 1'b1;
                        index_next   = fade_index;
                    end
                end
            end else begin
                tick_next = tick_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg    <= MODE_STEP;
            index_reg   <= CHANNELS'(RESET_INDEX);
            level_reg   <= '1;
            pwm_cnt_reg <= '0;
            fade_reg    <= '0;
            fade_up_reg <= 1'b1;
            tick_reg    <= '0;
            led_n_reg   <= '1;
        end else begin
            mode_reg    <= mode_next;
            index_reg   <= index_next;
            level_reg   <= level_next;
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            fade_reg    <= fade_next;
            fade_up_reg <= fade_up_next;
            tick_reg    <= tick_next;
            led_n_reg   <= led_n_next;
        end
    end

    // Top level reaches 2^PWM_BITS, which keeps the output on for the whole period.
    always_comb begin
        duty = (DUTY_W'(level_reg) + DUTY_W'(1)) << (PWM_BITS - LEVEL_BITS);
        if (mode_reg == MODE_FADE)
            duty = {1'b0, fade_reg};
    end

    assign pwm_on = ({1'b0, pwm_cnt_reg} < duty);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_led
        assign led_n_next[gi] = ~(index_reg[gi] & pwm_on);
    end

    assign led_n  = led_n_reg;
    assign mode_o = mode_reg;

endmodule

// File: tb/tb_pwm_color_mixer.sv
// Scoreboard bench for pwm_color_mixer: a behavioural model predicts LED/mode every cycle.
module tb_pwm_color_mixer;
    localparam int CH = 3, PB = 4, LB = 2, DB = 4, FT = 1;
    localparam int PERIOD    = 1 << PB;
    localparam int FADE_SPAN = 2 * (PERIOD - 1);

    logic clk = 1'b0, rst_n = 1'b0, btn_next = 1'b0, btn_mode = 1'b0;
    logic [CH-1:0] led_n;
    logic [1:0]    mode_o;

    pwm_color_mixer #(
        .CHANNELS(CH), .PWM_BITS(PB), .LEVEL_BITS(LB),
        .DEBOUNCE_CYCLES(DB), .FADE_TICKS(FT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_mode(btn_mode),
        .led_n(led_n), .mode_o(mode_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] led;
        logic [1:0]    mode;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0, n_fail = 0, cyc = 0;

    // Reference model state (values as held between clock edges).
    int m_s1[2], m_s2[2], m_lvl[2], m_run[2], m_press[2];
    int m_mode, m_index, m_level, m_pwm, m_phase, m_ticks;

    function automatic int fade_value(input int phase);
        return (phase <= PERIOD - 1) ? phase : FADE_SPAN - phase;
    endfunction

    task automatic reset_model();
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_run[b] = 0; m_press[b] = 0;
        end
        m_mode = 0; m_index = 0; m_level = (1 << LB) - 1;
        m_pwm = 0; m_phase = 0; m_ticks = 0;
    endtask

    task automatic model_step();
        exp_t e;
        int duty;
        int raw[2];
        raw[0] = int'(btn_next);
        raw[1] = int'(btn_mode);
        duty = (m_mode == 2) ? fade_value(m_phase) : (m_level + 1) * (PERIOD >> LB);
        for (int i = 0; i < CH; i++)
            e.led[i] = !((((m_index >> i) & 1) == 1) && (m_pwm < duty));
        if (m_press[1] != 0) begin
            m_mode = (m_mode + 1) % 3;
            if (m_mode == 2) begin m_phase = 0; m_ticks = 0; end
        end else begin
            if (m_press[0] != 0 && m_mode == 0) m_index = (m_index + 1) % (1 << CH);
            if (m_press[0] != 0 && m_mode == 1) m_level = (m_level + 1) % (1 << LB);
            if (m_mode == 2 && m_pwm == PERIOD - 1) begin
                m_ticks++;
                if (m_ticks == FT) begin
                    m_ticks = 0;
                    m_phase = (m_phase + 1) % FADE_SPAN;
                    if (m_phase == 0) begin
                        m_index = (m_index + 1) % (1 << CH);
                        if (m_index == 0) m_index = 1;
                    end
                end
            end
        end
        m_pwm = (m_pwm + 1) % PERIOD;
        // A button is accepted once its synchronised value has differed for DB cycles running.
        for (int b = 0; b < 2; b++) begin
            m_press[b] = 0;
            if (m_s2[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    m_lvl[b] = m_s2[b]; m_press[b] = m_s2[b]; m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
        e.mode = 2'(m_mode);
        exp_q.push_back(e);
    endtask

    initial begin : model_proc
        reset_model();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                reset_model();
                exp_q.delete();
            end else begin
                model_step();
            end
        end
    end

    initial begin : monitor_proc
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (led_n !== e.led || mode_o !== e.mode) begin
                    n_fail++;
                    $display("FAIL scoreboard cyc=%0d led_n act=%b req=%b mode_o act=%b req=%b",
                             cyc, led_n, e.led, mode_o, e.mode);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s act=%0d req=%0d", name, act, req);
        end
    endtask

    task automatic drive(input logic n, input logic m, input int cycles);
        btn_next = n;
        btn_mode = m;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic press(input logic n, input logic m);
        drive(n, m, $urandom_range(5, 10));
        drive(1'b0, 1'b0, $urandom_range(6, 10));
    endtask

    initial begin : stimulus
        int op;
        logic [6:0] bounce;
        repeat (3) @(negedge clk);
        check("reset_led_n", int'(led_n), 7);
        check("reset_mode_o", int'(mode_o), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        bounce = 7'b1011010;
        for (int i = 0; i < 7; i++) drive(bounce[i], 1'b0, 1);
        drive(1'b0, 1'b0, 6);
        drive(1'b1, 1'b0, 2);
        drive(1'b0, 1'b0, 8);
        $display("txn: bounce and short NEXT hold");
        drive(1'b1, 1'b0, 8);
        drive(1'b0, 1'b0, 8);
        $display("txn: NEXT held 8 cycles");
        for (int i = 0; i < 6; i++) begin
            press(1'b1, 1'b0);
            $display("txn: STEP NEXT press %0d", i);
        end
        drive(1'b0, 1'b0, 40);
        for (int i = 0; i < 2; i++) press(1'b1, 1'b0);
        $display("txn: STEP wrap through 0");
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        drive(1'b0, 1'b0, 40);
        $display("txn: BRIGHT level wrap to 0");
        press(1'b1, 1'b1);
        $display("txn: simultaneous MODE and NEXT");
        drive(1'b0, 1'b0, 3500);
        $display("txn: FADE run 3500 cycles");

        for (int t = 0; t < 250; t++) begin
            op = $urandom_range(0, 7);
            case (op)
                0, 1, 2: press(1'b1, 1'b0);
                3:       press(1'b0, 1'b1);
                4:       press(1'b1, 1'b1);
                5: begin
                    for (int i = 0; i < 10; i++)
                        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
                    drive(1'b0, 1'b0, 12);
                end
                6: begin
                    drive(1'b1, 1'b0, $urandom_range(1, 3));
                    drive(1'b0, 1'b0, 8);
                end
                default: drive(1'b0, 1'b0, $urandom_range(20, 200));
            endcase
            $display("txn %0d: op=%0d mode_o=%b led_n=%b", t, op, mode_o, led_n);
        end

        press(1'b0, 1'b1);
        drive(1'b0, 1'b0, 7);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_led_n", int'(led_n), 7);
        check("async_reset_mode_o", int'(mode_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("txn: mid-run reset");
        for (int i = 0; i < 7; i++) press(1'b1, 1'b0);
        drive(1'b0, 1'b0, 40);
        $display("txn: post-reset STEP walk to index 7");

        repeat (4) @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("scoreboard_active", int'(n_cmp > 5000), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
